kypd_hex_entry: RTL and testbench
=================================

// Module: kypd_hex_entry
// PURPOSE
//  Input-side counterpart of the board's multiplexed 7-seg display driver: scans a 4x4 Pmod KYPD hex keypad
//  by driving columns low one at a time and reading rows. Debounces presses and delivers each press over a
//  valid/ready handshake. Also shifts each digit into a hex entry register that feeds the core's switch/data
//  input in place of SW.
// PARAMETERS
//  SCAN_DIV        1000  clock cycles per column window; must be >= 3
//  DEBOUNCE_SCANS  4     consecutive full scans a press or release must be stable; must be >= 1
//  DIGITS          4     hex digits held in value_o
// PORTS
//  CLK100       in   1          system clock, all logic on rising edge
//  resetn       in   1          asynchronous, active-low reset
//  col_o        out  4          keypad columns, active-low one-cold
//  row_i        in   4          keypad rows, active-low (pulled up), asynchronous
//  key_valid_o  out  1          debounced key available
//  key_code_o   out  4          hex code of the key; stable while key_valid_o=1
//  key_ready_i  in   1          consumer accepts; transfer on edge with valid&ready
//  value_o      out  4*DIGITS   hex entry register, newest digit in [3:0]
//  key_ovf_o    out  1          sticky: key lost because previous one not yet accepted
//  clr_i        in   1          synchronous clear of value_o and key_ovf_o
// BEHAVIOUR
//  Reset values: col_o=4'b1110, key_valid_o=0, key_code_o=0, value_o=0, key_ovf_o=0.
//  Reset state: FSM IDLE, all counters 0, row synchroniser=4'hF. Reset mid-operation aborts everything to these.
//  Row synchroniser:
//   - row_i passes through 2 flops; 2-cycle latency.
//  Column scan:
//   - div counter runs 0..SCAN_DIV-1.
//   - Rows are sampled at div==SCAN_DIV-1. On the following edge, col_o rotates 1110->1101->1011->0111->1110.
//   - A full scan is 4 windows (4*SCAN_DIV cycles). The result is evaluated at the end of the col3 window.
//   - Result is NONE (no low rows seen), SINGLE(k) (exactly one low bit over all 4 samples), or MULTI.
//  Key map [row][col0..3]:
//   - r0: 1 2 3 A
//   - r1: 4 5 6 B
//   - r2: 7 8 9 C
//   - r3: 0 F E D
//  Debounce FSM (steps once per full scan; cnt counts scans):
//   - IDLE: SINGLE(k) -> cand=k, cnt=1, PRESS_CHK. NONE or MULTI -> stay in IDLE.
//   - PRESS_CHK: SINGLE(cand) -> cnt+1; reaching DEBOUNCE_SCANS -> EMIT then HELD.
//     Anything else -> IDLE, cnt=0.
//   - HELD: NONE -> cnt=1, RELEASE_CHK. Otherwise stay; no autorepeat.
//   - RELEASE_CHK: NONE -> cnt+1; reaching DEBOUNCE_SCANS -> IDLE. Otherwise -> HELD.
//   - With DEBOUNCE_SCANS=1, the first SINGLE(k) goes straight to EMIT, and the first NONE in HELD goes straight to IDLE.
//  EMIT (single-cycle event, registered; visible the edge after the scan end):
//   - value_o <= {value_o[4*DIGITS-5:0], cand}; the oldest digit is discarded.
//   - If key_valid_o=0, or key_valid_o&key_ready_i in the same cycle: key_code_o<=cand, key_valid_o<=1.
//   - Otherwise the key is dropped from the handshake (value_o still shifts), key_code_o is unchanged, and key_ovf_o<=1.
//  Handshake:
//   - key_valid_o & key_ready_i at an edge with no EMIT -> key_valid_o<=0.
//   - key_code_o never changes while key_valid_o=1 and not accepted.
//  clr_i:
//   - value_o<=0, key_ovf_o<=0; clr_i wins over a same-cycle EMIT shift.
//   - Handshake and FSM are not affected.
//  Latency from a stable press starting at a scan boundary: DEBOUNCE_SCANS*4*SCAN_DIV + 1 cycles to key_valid_o.
// TESTING (SCAN_DIV=8, DEBOUNCE_SCANS=2; scan=32 cycles)
//  1 Reset: hold resetn=0 -> col_o=1110, all outputs 0; release -> col_o=1101 after 8 cycles, 1110 again after 32.
//  2 Hold key 5 (row1 low while col1 active), key_ready_i=1 -> key_valid_o=1, key_code_o=5 one edge after 2nd scan;
//    value_o=16'h0005; valid drops next cycle.
//  3 Press/release 1,2,3,A then F (clean) -> value_o=16'h123A, then 16'h23AF; five handshakes, key_ovf_o=0.
//  4 Key 7 for one scan then released; key 8 held long after emission -> no emission for 7;
//    exactly one emission for 8.
//  5 key_ready_i=0; press 8, release, press 9 -> key_code_o stays 8, key_ovf_o=1, value_o=16'h0089;
//    clr_i pulse -> value_o=0, key_ovf_o=0, key_valid_o still 1.
//  6 Keys 1 and 2 together for 3 scans -> no emission; resetn low mid-PRESS_CHK -> outputs at reset values.
//    After release of reset, a fresh press emits normally.

Source files
------------

// File: rtl/kypd_hex_entry_if.sv
// Key handshake between the keypad scanner (master) and its consumer (slave).
interface kypd_hex_entry_if;
   logic       key_valid_o;
   logic [3:0] key_code_o;
   logic       key_ready_i;

   modport master (output key_valid_o, output key_code_o, input key_ready_i);
   modport slave  (input key_valid_o, input key_code_o, output key_ready_i);
endinterface

// File: rtl/kypd_hex_entry.sv
// 4x4 hex keypad scanner: column scan, per-scan press/release debounce,
// valid/ready key delivery and a shifting hex entry register.
module kypd_hex_entry #(
   parameter int unsigned SCAN_DIV       = 1000,
   parameter int unsigned DEBOUNCE_SCANS = 4,
   parameter int unsigned DIGITS         = 4
) (
   input  logic                  CLK100,
   input  logic                  resetn,
   output logic [3:0]            col_o,
   input  logic [3:0]            row_i,
   output logic [4*DIGITS-1:0]   value_o,
   output logic                  key_ovf_o,
   input  logic                  clr_i,
   kypd_hex_entry_if.master      kif
);

   localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned CNT_W = $clog2(DEBOUNCE_SCANS + 1);
   localparam int unsigned VAL_W = 4 * DIGITS;

   typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, RELEASE_CHK} state_t;

   logic [3:0]       row_s1, row_s2;
   logic [DIV_W-1:0] div;
   logic [1:0]       col_idx;
   logic [1:0]       acc_n;
   logic [3:0]       acc_code;
   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [3:0]       cand;
   logic             emit;
   logic             valid_q;
   logic [3:0]       code_q;

   logic [3:0]       samp_low;
   logic [2:0]       samp_n;
   logic [1:0]       samp_row;
   logic [2:0]       sum_n;
   logic [3:0]       scan_code;
   logic             win_end, scan_end, scan_none, scan_single;
   logic [CNT_W-1:0] cnt_inc;

   assign kif.key_valid_o = valid_q;
   assign kif.key_code_o  = code_q;

   // Keypad legend indexed by row and active column.
   function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
      logic [3:0] k;
      case ({r, c})
         4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
         4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
         4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
         4'hC: k = 4'h0;  4'hD: k = 4'hF;  4'hE: k = 4'hE;  default: k = 4'hD;
      endcase
      return k;
   endfunction

   // Classify the current row sample together with what the scan has seen so far.
   always_comb begin
      samp_low = ~row_s2;
      samp_n   = '0;
      samp_row = '0;
      for (int i = 0; i < 4; i++) begin
         if (samp_low[i]) begin
            samp_n   = samp_n + 3'd1;
            samp_row = 2'(i);
         end
      end
      sum_n       = 3'({1'b0, acc_n}) + samp_n;
      scan_code   = (acc_n == 2'd1) ? acc_code : key_map(samp_row, col_idx);
      win_end     = (div == DIV_W'(SCAN_DIV - 1));
      scan_end    = win_end && (col_idx == 2'd3);
      scan_none   = (sum_n == 3'd0);
      scan_single = (sum_n == 3'd1);
      cnt_inc     = cnt + CNT_W'(1);
   end

   // Two-flop row synchroniser.
   always_ff @(posedge CLK100 or negedge resetn) begin
      if (!resetn) begin
         row_s1 <= 4'hF;
         row_s2 <= 4'hF;
      end else begin
         row_s1 <= row_i;
         row_s2 <= row_s1;
      end
   end

   // Column window divider, column rotation and per-scan low-row accumulation.
   always_ff @(posedge CLK100 or negedge resetn) begin
      if (!resetn) begin
         div      <= '0;
         col_idx  <= '0;
         col_o    <= 4'b1110;
         acc_n    <= '0;
         acc_code <= '0;
      end else if (win_end) begin
         div      <= '0;
         col_idx  <= col_idx + 2'd1;
         col_o    <= {col_o[2:0], col_o[3]};
         if (scan_end) begin
            acc_n    <= '0;
            acc_code <= '0;
         end else begin
            acc_n    <= (sum_n >= 3'd2) ? 2'd2 : sum_n[1:0];
            acc_code <= scan_code;
         end
      end else begin
         div <= div + DIV_W'(1);
      end
   end

   // Debounce FSM, stepped once per completed scan; emit is a one-cycle event.
   always_ff @(posedge CLK100 or negedge resetn) begin
      if (!resetn) begin
         state <= IDLE;
         cnt   <= '0;
         cand  <= '0;
         emit  <= 1'b0;
      end else begin
         emit <= 1'b0;
         if (scan_end) begin
            case (state)
               IDLE: begin
                  if (scan_single) begin
                     cand <= scan_code;
                     if (DEBOUNCE_SCANS == 1) begin
                        emit  <= 1'b1;
                        state <= HELD;
                     end else begin
                        cnt   <= CNT_W'(1);
                        state <= PRESS_CHK;
                     end
                  end
               end
               PRESS_CHK: begin
                  if (scan_single && (scan_code == cand)) begin
                     if (cnt_inc == CNT_W'(DEBOUNCE_SCANS)) begin
                        emit  <= 1'b1;
                        state <= HELD;
                     end else begin
                        cnt <= cnt_inc;
                     end
                  end else begin
                     cnt   <= '0;
                     state <= IDLE;
                  end
               end
               HELD: begin
                  if (scan_none) begin
                     if (DEBOUNCE_SCANS == 1) begin
                        cnt   <= '0;
                        state <= IDLE;
                     end else begin
                        cnt   <= CNT_W'(1);
                        state <= RELEASE_CHK;
                     end
                  end
               end
               default: begin
                  if (scan_none) begin
                     if (cnt_inc == CNT_W'(DEBOUNCE_SCANS)) begin
                        cnt   <= '0;
                        state <= IDLE;
                     end else begin
                        cnt <= cnt_inc;
                     end
                  end else begin
                     state <= HELD;
                  end
               end
            endcase
         end
      end
   end

   // Entry register shift, key handshake and overflow flag; clear beats a shift.
   always_ff @(posedge CLK100 or negedge resetn) begin
      if (!resetn) begin
         value_o   <= '0;
         key_ovf_o <= 1'b0;
         valid_q   <= 1'b0;
         code_q    <= '0;
      end else begin
         if (emit) begin
            value_o <= {value_o[VAL_W-5:0], cand};
            if (!valid_q || kif.key_ready_i) begin
               code_q  <= cand;
               valid_q <= 1'b1;
            end else begin
               key_ovf_o <= 1'b1;
            end
         end else if (valid_q && kif.key_ready_i) begin
            valid_q <= 1'b0;
         end
         if (clr_i) begin
            value_o   <= '0;
            key_ovf_o <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_kypd_hex_entry.sv
// Bench for kypd_hex_entry with a simulated keypad and a scan-level behavioural model.
module tb_kypd_hex_entry;

   localparam int unsigned SD   = 8;
   localparam int unsigned DB   = 2;
   localparam int unsigned SCAN = 4 * SD;

   logic        CLK100 = 1'b0;
   logic        resetn;
   logic [3:0]  col_o;
   logic [3:0]  row_i;
   logic [15:0] value_o;
   logic        key_ovf_o;
   logic        clr_i;
   logic [15:0] keys;

   kypd_hex_entry_if kif();

   kypd_hex_entry #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB), .DIGITS(4)) dut (
      .CLK100    (CLK100),
      .resetn    (resetn),
      .col_o     (col_o),
      .row_i     (row_i),
      .value_o   (value_o),
      .key_ovf_o (key_ovf_o),
      .clr_i     (clr_i),
      .kif       (kif.master)
   );

   always #5 CLK100 = ~CLK100;

   int vectors = 0;
   int errors  = 0;
   int hs_cnt  = 0;
   int edge_cnt;

   // expected outputs
   logic [15:0] m_value;
   logic [3:0]  m_code, m_cand;
   logic        m_valid, m_ovf, m_emit;
   // scan-level debounce model
   bit          held, pending;
   int          run, rel;
   logic [3:0]  pcand;

   // Physical position (row*4+col) of each hex key.
   function automatic int key_pos(input int code);
      case (code)
         0: return 12;  1: return 0;   2: return 1;   3: return 2;
         4: return 4;   5: return 5;   6: return 6;   7: return 8;
         8: return 9;   9: return 10;  10: return 3;  11: return 7;
         12: return 11; 13: return 15; 14: return 14; default: return 13;
      endcase
   endfunction

   // Keypad: a pressed key pulls its row low while its column is driven low.
   always_comb begin
      row_i = 4'hF;
      for (int k = 0; k < 16; k++)
         if (keys[k] && !col_o[key_pos(k) % 4]) row_i[key_pos(k) / 4] = 1'b0;
   end

   task automatic model_reset();
      m_value = '0; m_code = '0; m_cand = '0;
      m_valid = 0; m_ovf = 0; m_emit = 0;
      held = 0; pending = 0; run = 0; rel = 0; pcand = '0;
      edge_cnt = 0;
   endtask

   // A key is accepted after DB consecutive scans with only that key down,
   // and another only after DB consecutive scans with nothing down.
   task automatic scan_model();
      int n;
      logic [3:0] k;
      n = $countones(keys);
      k = '0;
      for (int i = 0; i < 16; i++) if (keys[i]) k = 4'(i);
      if (held) begin
         if (n == 0) begin
            rel++;
            if (rel == DB) held = 0;
         end else rel = 0;
      end else if (pending) begin
         if (n == 1 && k == pcand) begin
            run++;
            if (run == DB) begin
               m_emit = 1; m_cand = k; held = 1; rel = 0; pending = 0;
            end
         end else begin
            pending = 0; run = 0;
         end
      end else if (n == 1) begin
         pcand = k; run = 1;
         if (run == DB) begin
            m_emit = 1; m_cand = k; held = 1; rel = 0;
         end else pending = 1;
      end
   endtask

   // One clock: drive at negedge, advance the model at the edge, return at next negedge.
   task automatic cycle(input logic rdy, input logic clr);
      kif.key_ready_i = rdy;
      clr_i = clr;
      if (kif.key_valid_o && rdy) hs_cnt++;
      @(posedge CLK100);
      if (m_emit) begin
         if (!clr) m_value = {m_value[11:0], m_cand};
         if (!m_valid || rdy) begin
            m_code = m_cand; m_valid = 1;
         end else m_ovf = 1;
      end else if (m_valid && rdy) m_valid = 0;
      if (clr) begin m_value = '0; m_ovf = 0; end
      m_emit = 0;
      edge_cnt++;
      if (edge_cnt % SCAN == 0) scan_model();
      @(negedge CLK100);
   endtask

   task automatic cycles(input int n, input logic rdy);
      repeat (n) cycle(rdy, 1'b0);
   endtask

   task automatic scans(input logic [15:0] mask, input int n, input logic rdy);
      keys = mask;
      cycles(n * SCAN, rdy);
   endtask

   task automatic test_reset();
      logic [3:0] exp_col;
      resetn = 0; keys = '0; clr_i = 0; kif.key_ready_i = 0;
      repeat (3) @(negedge CLK100);
      vectors++; if (col_o !== 4'b1110) begin errors++; $display("FAIL reset_col got %b exp 1110", col_o); end
      vectors++; if (kif.key_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", kif.key_valid_o); end
      vectors++; if (kif.key_code_o !== 4'h0) begin errors++; $display("FAIL reset_code got %h exp 0", kif.key_code_o); end
      vectors++; if (value_o !== 16'h0) begin errors++; $display("FAIL reset_value got %h exp 0", value_o); end
      vectors++; if (key_ovf_o !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", key_ovf_o); end
      resetn = 1;
      model_reset();
      for (int i = 1; i <= SCAN; i++) begin
         cycle(1'b0, 1'b0);
         exp_col = 4'b1111;
         exp_col[(i / SD) % 4] = 1'b0;
         vectors++; if (col_o !== exp_col) begin errors++; $display("FAIL col_scan cyc %0d got %b exp %b", i, col_o, exp_col); end
      end
      vectors++; if (col_o !== 4'b1110) begin errors++; $display("FAIL col_wrap got %b exp 1110", col_o); end
   endtask

   task automatic test_single_key();
      hs_cnt = 0;
      scans(16'h0020, DB, 1'b1);
      vectors++; if (kif.key_valid_o !== 1'b0) begin errors++; $display("FAIL key5_early got %b exp 0", kif.key_valid_o); end
      cycle(1'b1, 1'b0);
      vectors++; if (kif.key_valid_o !== 1'b1) begin errors++; $display("FAIL key5_valid got %b exp 1", kif.key_valid_o); end
      vectors++; if (kif.key_code_o !== 4'h5) begin errors++; $display("FAIL key5_code got %h exp 5", kif.key_code_o); end
      vectors++; if (value_o !== 16'h0005) begin errors++; $display("FAIL key5_value got %h exp 0005", value_o); end
      cycle(1'b1, 1'b0);
      vectors++; if (kif.key_valid_o !== 1'b0) begin errors++; $display("FAIL key5_drop got %b exp 0", kif.key_valid_o); end
      cycles(SCAN - 2, 1'b1);
      scans(16'h0000, DB, 1'b1);
   endtask

   task automatic test_sequence();
      logic [3:0] seq [5] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'hF};
      hs_cnt = 0;
      for (int i = 0; i < 5; i++) begin
         scans(16'(1) << seq[i], DB, 1'b1);
         scans(16'h0000, DB, 1'b1);
         if (i == 3) begin
            vectors++; if (value_o !== 16'h123A) begin errors++; $display("FAIL seq_value4 got %h exp 123A", value_o); end
         end
      end
      vectors++; if (value_o !== 16'h23AF) begin errors++; $display("FAIL seq_value5 got %h exp 23AF", value_o); end
      vectors++; if (hs_cnt != 5) begin errors++; $display("FAIL seq_handshakes got %0d exp 5", hs_cnt); end
      vectors++; if (key_ovf_o !== 1'b0) begin errors++; $display("FAIL seq_ovf got %b exp 0", key_ovf_o); end
   endtask

   task automatic test_debounce();
      hs_cnt = 0;
      scans(16'h0080, 1, 1'b1);
      scans(16'h0000, DB, 1'b1);
      vectors++; if (hs_cnt != 0) begin errors++; $display("FAIL bounce7_emitted got %0d exp 0", hs_cnt); end
      scans(16'h0100, 6, 1'b1);
      scans(16'h0000, DB, 1'b1);
      vectors++; if (hs_cnt != 1) begin errors++; $display("FAIL hold8_count got %0d exp 1", hs_cnt); end
      vectors++; if (value_o !== 16'h3AF8) begin errors++; $display("FAIL hold8_value got %h exp 3AF8", value_o); end
   endtask

   task automatic test_overflow();
      cycle(1'b0, 1'b1);
      cycles(SCAN - 1, 1'b0);
      scans(16'h0100, DB, 1'b0);
      scans(16'h0000, DB, 1'b0);
      scans(16'h0200, DB, 1'b0);
      scans(16'h0000, DB, 1'b0);
      vectors++; if (kif.key_code_o !== 4'h8) begin errors++; $display("FAIL ovf_code got %h exp 8", kif.key_code_o); end
      vectors++; if (key_ovf_o !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", key_ovf_o); end
      vectors++; if (value_o !== 16'h0089) begin errors++; $display("FAIL ovf_value got %h exp 0089", value_o); end
      cycle(1'b0, 1'b1);
      vectors++; if (value_o !== 16'h0) begin errors++; $display("FAIL clr_value got %h exp 0", value_o); end
      vectors++; if (key_ovf_o !== 1'b0) begin errors++; $display("FAIL clr_ovf got %b exp 0", key_ovf_o); end
      vectors++; if (kif.key_valid_o !== 1'b1) begin errors++; $display("FAIL clr_valid got %b exp 1", kif.key_valid_o); end
      cycles(SCAN - 1, 1'b1);
   endtask

   task automatic test_multi_reset();
      hs_cnt = 0;
      scans(16'h0006, 3, 1'b1);
      scans(16'h0000, DB, 1'b1);
      vectors++; if (hs_cnt != 0) begin errors++; $display("FAIL multi_emitted got %0d exp 0", hs_cnt); end
      vectors++; if (value_o !== 16'h0) begin errors++; $display("FAIL multi_value got %h exp 0", value_o); end
      scans(16'h0040, DB, 1'b0);
      scans(16'h0000, DB, 1'b0);
      vectors++; if (value_o !== 16'h0006) begin errors++; $display("FAIL pre_rst_value got %h exp 0006", value_o); end
      scans(16'h0008, 1, 1'b0);
      cycles(10, 1'b0);
      resetn = 0;
      @(negedge CLK100); @(negedge CLK100);
      vectors++; if (col_o !== 4'b1110) begin errors++; $display("FAIL midrst_col got %b exp 1110", col_o); end
      vectors++; if (kif.key_valid_o !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b exp 0", kif.key_valid_o); end
      vectors++; if (kif.key_code_o !== 4'h0) begin errors++; $display("FAIL midrst_code got %h exp 0", kif.key_code_o); end
      vectors++; if (value_o !== 16'h0) begin errors++; $display("FAIL midrst_value got %h exp 0", value_o); end
      keys = '0;
      resetn = 1;
      model_reset();
      hs_cnt = 0;
      scans(16'h0010, DB, 1'b1);
      cycle(1'b1, 1'b0);
      vectors++; if (kif.key_valid_o !== 1'b1 || kif.key_code_o !== 4'h4) begin errors++; $display("FAIL post_rst_key got v=%b c=%h exp v=1 c=4", kif.key_valid_o, kif.key_code_o); end
      vectors++; if (value_o !== 16'h0004) begin errors++; $display("FAIL post_rst_value got %h exp 0004", value_o); end
      cycles(SCAN - 1, 1'b1);
      scans(16'h0000, DB, 1'b1);
   endtask

   task automatic test_random();
      logic [15:0] mask;
      int r, a, b;
      logic rdy, clr;
      mask = '0;
      for (int s = 0; s < 48; s++) begin
         if ($urandom_range(0, 99) >= 55) begin
            r = $urandom_range(0, 99);
            if (r < 45) mask = '0;
            else if (r < 85) mask = 16'(1) << $urandom_range(0, 15);
            else begin
               a = $urandom_range(0, 15);
               b = (a + $urandom_range(1, 15)) % 16;
               mask = (16'(1) << a) | (16'(1) << b);
            end
         end
         keys = mask;
         for (int c = 0; c < SCAN; c++) begin
            rdy = ($urandom_range(0, 99) < 60);
            clr = ($urandom_range(0, 99) < 2);
            cycle(rdy, clr);
            vectors++; if (kif.key_valid_o !== m_valid) begin errors++; $display("FAIL rnd_valid e=%0d got %b exp %b", edge_cnt, kif.key_valid_o, m_valid); end
            vectors++; if (kif.key_code_o !== m_code) begin errors++; $display("FAIL rnd_code e=%0d got %h exp %h", edge_cnt, kif.key_code_o, m_code); end
            vectors++; if (value_o !== m_value) begin errors++; $display("FAIL rnd_value e=%0d got %h exp %h", edge_cnt, value_o, m_value); end
            vectors++; if (key_ovf_o !== m_ovf) begin errors++; $display("FAIL rnd_ovf e=%0d got %b exp %b", edge_cnt, key_ovf_o, m_ovf); end
         end
      end
   endtask

   initial begin
      resetn = 0; keys = '0; clr_i = 0; kif.key_ready_i = 0;
      @(negedge CLK100);
      test_reset();
      test_single_key();
      test_sequence();
      test_debounce();
      test_overflow();
      test_multi_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
